// File: rtl/alu_shift_sequencer.sv
// Multi-cycle shift unit: walks an operand through a left-shift step of up to 2**STEP_W-1
// positions per cycle; right shifts run on a bit-reversed copy and are reversed back on output.
module alu_shift_sequencer #(
   parameter int WIDTH  = 32,
   parameter int AMT_W  = 5,
   parameter int STEP_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [AMT_W-1:0] sh_amt,
   input  logic [1:0]       sh_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] result,
   output logic             res_zero,
   output logic [1:0]       dbg_state_o
);

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // the producer holds valid and its payload stable until that edge.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [AMT_W-1:0] MAX_STEP = AMT_W'((1 << STEP_W) - 1);
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic             fill_q, fill_d;
   logic             rev_q, rev_d;
   logic             live_q;
   logic [AMT_W-1:0] step;
   logic             is_right;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
      return r;
   endfunction

   // live_q keeps start_ready low until the first edge after reset is released.
   assign start_ready = live_q && (state_q == IDLE);
   assign res_valid   = (state_q == DONE);
   assign result      = rev_q ? bit_rev(data_q) : data_q;
   assign res_zero    = res_valid && (result == '0);
   assign dbg_state_o = state_q;
   assign is_right    = (sh_op == OP_SRL) || (sh_op == OP_SRA);
   assign step        = (rem_q > MAX_STEP) ? MAX_STEP : rem_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      fill_d  = fill_q;
      rev_d   = rev_q;
      case (state_q)
         IDLE: begin
            if (start_valid && start_ready) begin
               data_d  = is_right ? bit_rev(op_a) : op_a;
               rem_d   = sh_amt;
               fill_d  = (sh_op == OP_SRA) ? op_a[WIDTH-1] : 1'b0;
               rev_d   = is_right;
               state_d = (sh_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            // Vacated low bits take fill_q, which carries the sign for SRA.
            data_d = (data_q << step) | (fill_q ? ~({WIDTH{1'b1}} << step) : '0);
            rem_d  = rem_q - step;
            if (rem_q <= MAX_STEP) state_d = DONE;
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         fill_q  <= 1'b0;
         rev_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         fill_q  <= fill_d;
         rev_q   <= rev_d;
         live_q  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_alu_shift_sequencer.sv
// Directed bench for alu_shift_sequencer with a result/latency scoreboard.
module tb_alu_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [31:0] op_a = '0;
   logic [4:0]  sh_amt = '0;
   logic [1:0]  sh_op = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] result;
   logic        res_zero;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];
   int          lat_q[$];

   always #5 clk = ~clk;

   alu_shift_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .op_a        (op_a),
      .sh_amt      (sh_amt),
      .sh_op       (sh_op),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .result      (result),
      .res_zero    (res_zero),
      .dbg_state_o (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [4:0] amt);
      case (op)
         2'b01:   return a >> amt;
         2'b10:   return 32'($signed(a) >>> amt);
         default: return a << amt;
      endcase
   endfunction

   // Drive a request and hold it until the accept edge; returns just after that edge.
   task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [4:0] amt);
      int guard = 0;
      while (!start_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      check("ready_before_req", {31'd0, start_ready}, 32'd1);
      start_valid = 1'b1; op_a = a; sh_amt = amt; sh_op = op;
      exp_q.push_back(model(op, a, amt));
      lat_q.push_back(1 + (int'(amt) + 6) / 7);
      @(posedge clk); #1;
   endtask

   // Count edges from the accept edge until res_valid, then compare against the scoreboard.
   task automatic collect(input string tag);
      int lat = 1;
      logic [31:0] exp_r;
      int exp_l;
      while (!res_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
      exp_r = exp_q.pop_front();
      exp_l = lat_q.pop_front();
      check({tag, "_latency"}, lat, exp_l);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_zero"}, {31'd0, res_zero}, {31'd0, exp_r == 32'd0});
   endtask

   task automatic consume(input string tag);
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check({tag, "_released"}, {30'd0, res_valid, start_ready}, 32'd1);
   endtask

   task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] amt);
      drive_req(op, a, amt);
      start_valid = 1'b0;
      collect(tag);
      consume(tag);
   endtask

   initial begin
      int seen;
      // Reset state
      #2;
      check("rst_ready", {31'd0, start_ready}, 32'd0);
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'd0, res_zero}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("ready_before_edge", {31'd0, start_ready}, 32'd0);
      @(posedge clk); #1;
      check("ready_after_edge", {31'd0, start_ready}, 32'd1);

      // Abort an in-flight SHIFT with reset
      drive_req(2'b00, 32'h1, 5'd31);
      start_valid = 1'b0;
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
      @(posedge clk); #1;
      rst_n = 1'b0; #1;
      check("abort_ready_low", {31'd0, start_ready}, 32'd0);
      check("abort_valid_low", {31'd0, res_valid}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      check("abort_ready_after", {31'd0, start_ready}, 32'd1);

      // Directed cases
      run_req("sll31", 2'b00, 32'h0000_0001, 5'd31);
      check("sll31_exp", model(2'b00, 32'h1, 5'd31), 32'h8000_0000);
      run_req("sra4", 2'b10, 32'h8000_0000, 5'd4);
      run_req("srl4", 2'b01, 32'h8000_0000, 5'd4);
      run_req("amt0", 2'b01, 32'hDEAD_BEEF, 5'd0);
      run_req("sll7", 2'b00, 32'h1234_5678, 5'd7);
      run_req("rsv_op", 2'b11, 32'h0000_00FF, 5'd12);

      // Result held while downstream stalls
      drive_req(2'b00, 32'h8000_0000, 5'd1);
      start_valid = 1'b0;
      collect("sll_zero");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_result", result, 32'd0);
         check("hold_flags", {29'd0, res_valid, res_zero, start_ready}, 32'b110);
      end
      consume("sll_zero");

      // Back-to-back with start_valid held high
      drive_req(2'b00, 32'h0000_000F, 5'd8);
      op_a = 32'h0000_0F00; sh_amt = 5'd8; sh_op = 2'b01;
      collect("b2b_a");
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check("b2b_idle", {30'd0, res_valid, start_ready}, 32'd1);
      exp_q.push_back(model(2'b01, 32'h0000_0F00, 5'd8));
      lat_q.push_back(3);
      @(posedge clk); #1;
      start_valid = 1'b0;
      check("b2b_b_accepted", {31'd0, start_ready}, 32'd0);
      collect("b2b_b");
      consume("b2b_b");

      // Random mix across all ops and amounts
      for (int i = 0; i < 12; i++) begin
         run_req("rand", 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
